// File: rtl/pong_game_fsm.sv
// Pong match sequencer: serve/play/point/over flow, both scores,
// and the ball/AI control strobes.
module pong_game_fsm #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int SCORE_W      = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic [2:0]         state,
  output logic               ball_reset,
  output logic               ball_launch,
  output logic               serve_dir,
  output logic               ai_enable,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               game_over,
  output logic               winner
);

  localparam int MAXF = (SERVE_FRAMES > POINT_FRAMES) ?
                        SERVE_FRAMES : POINT_FRAMES;
  localparam int CW = $clog2(MAXF + 1);
  localparam logic [CW-1:0] SF = CW'(SERVE_FRAMES);
  localparam logic [CW-1:0] PF = CW'(POINT_FRAMES);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t             st, st_n;
  logic [CW-1:0]      cnt, cnt_n, cnt_inc;
  logic [SCORE_W-1:0] sl_n, sr_n;
  logic               dir_n, launch_n, win_n, hit_win;

  assign cnt_inc = cnt + CW'(1);
  assign hit_win = (score_left == WIN) || (score_right == WIN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st          <= IDLE;
      cnt         <= '0;
      score_left  <= '0;
      score_right <= '0;
      serve_dir   <= 1'b1;
      ball_launch <= 1'b0;
      winner      <= 1'b0;
    end else begin
      st          <= st_n;
      cnt         <= cnt_n;
      score_left  <= sl_n;
      score_right <= sr_n;
      serve_dir   <= dir_n;
      ball_launch <= launch_n;
      winner      <= win_n;
    end
  end

  always_comb begin
    st_n     = st;
    cnt_n    = cnt;
    sl_n     = score_left;
    sr_n     = score_right;
    dir_n    = serve_dir;
    launch_n = 1'b0;
    win_n    = winner;
    case (st)
      IDLE, OVER: begin
        if (start) begin
          st_n  = SERVE;
          cnt_n = '0;
          sl_n  = '0;
          sr_n  = '0;
          dir_n = 1'b1;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (cnt_inc == SF) begin
            st_n     = PLAY;
            cnt_n    = '0;
            launch_n = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      PLAY: begin
        // simultaneous misses replay the point without scoring
        if (miss_left || miss_right) begin
          st_n  = POINT;
          cnt_n = '0;
        end
        if (miss_left && !miss_right) begin
          sr_n  = score_right + SCORE_W'(1);
          dir_n = 1'b0;
        end
        if (miss_right && !miss_left) begin
          sl_n  = score_left + SCORE_W'(1);
          dir_n = 1'b1;
        end
      end
      POINT: begin
        if (frame_tick) begin
          if (cnt_inc == PF) begin
            cnt_n = '0;
            if (hit_win) begin
              st_n  = OVER;
              win_n = (score_right == WIN);
            end else begin
              st_n = SERVE;
            end
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      default: begin
        st_n  = IDLE;
        cnt_n = '0;
      end
    endcase
  end

  assign state      = st;
  assign ball_reset = (st != PLAY);
  assign ai_enable  = (st == PLAY);
  assign game_over  = (st == OVER);

endmodule
